// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants, state encoding and CRC helper.
// Imported by the framer and its CRC step function.
package eth_pkg;

  localparam int ETH_HDR_LEN     = 14;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;
  localparam int ETH_FCS_LEN     = 4;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_REQ,
    ST_WAIT_ACK_LOW
  } tx_state_t;

  function automatic logic [31:0] rev32(
    input logic [31:0] v
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first shift register wants the bit-reversed polynomial
  localparam logic [31:0] CRC32_POLY_REF =
    rev32(CRC32_POLY);

endpackage

// File: rtl/crc32_d8.sv
// One byte step of reflected CRC-32, purely combinational.
// The CRC register itself lives in the framer.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i])
        c = (c >> 1) ^ CRC32_POLY_REF;
      else
        c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: header, payload, pad and FCS into a FIFO,
// then a 4-phase word_count handoff to the GMII stage.
module eth_tx_framer
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  fifo_wr_data,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic [10:0] word_count,
  output logic        word_count_ready,
  input  logic        word_count_ack,
  output logic        err_oversize
);

  localparam logic [3:0] HDR_LAST =
    4'(ETH_HDR_LEN - 1);
  localparam logic [10:0] PAY_MAX =
    11'(ETH_MAX_PAYLOAD);
  localparam logic [10:0] PAD_LAST =
    11'(ETH_MIN_PAYLOAD - 1);
  localparam logic [1:0] FCS_LAST =
    2'(ETH_FCS_LEN - 1);

  tx_state_t    state;
  logic [111:0] hdr;
  logic [31:0]  crc;
  logic [31:0]  crc_nxt;
  logic [31:0]  crc_sh;
  logic [7:0]   crc_din;
  logic [7:0]   fcs_byte;
  logic [10:0]  pay_cnt;
  logic [10:0]  tot_cnt;
  logic [3:0]   hdr_cnt;
  logic [1:0]   fcs_idx;
  logic         ack_s1;
  logic         ack_s2;
  logic         accept;

  assign s_ready = (state == ST_PAYLOAD)
                 & ~fifo_full & ~rst;
  assign accept  = s_valid & s_ready;

  assign crc_din =
    (state == ST_HEADER)  ? hdr[111:104] :
    (state == ST_PAYLOAD) ? s_data : 8'h00;

  assign crc_sh   = crc >> {fcs_idx, 3'b000};
  assign fcs_byte = ~crc_sh[7:0];

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_din),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      ack_s1           <= 1'b0;
      ack_s2           <= 1'b0;
      hdr              <= '0;
      crc              <= CRC32_INIT;
      pay_cnt          <= '0;
      tot_cnt          <= '0;
      hdr_cnt          <= '0;
      fcs_idx          <= '0;
      fifo_wr          <= 1'b0;
      fifo_wr_data     <= '0;
      word_count       <= '0;
      word_count_ready <= 1'b0;
      err_oversize     <= 1'b0;
    end else begin
      ack_s1       <= word_count_ack;
      ack_s2       <= ack_s1;
      fifo_wr      <= 1'b0;
      err_oversize <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (s_valid && !ack_s2) begin
            hdr     <= {dst_mac, src_mac,
                        ethertype};
            crc     <= CRC32_INIT;
            pay_cnt <= '0;
            tot_cnt <= '0;
            hdr_cnt <= '0;
            fcs_idx <= '0;
            state   <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!fifo_full) begin
            fifo_wr      <= 1'b1;
            fifo_wr_data <= hdr[111:104];
            hdr          <= {hdr[103:0], 8'h00};
            crc          <= crc_nxt;
            tot_cnt      <= tot_cnt + 11'd1;
            hdr_cnt      <= hdr_cnt + 4'd1;
            if (hdr_cnt == HDR_LAST)
              state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            // bytes past the cap are swallowed
            if (pay_cnt < PAY_MAX) begin
              fifo_wr      <= 1'b1;
              fifo_wr_data <= s_data;
              crc          <= crc_nxt;
              pay_cnt      <= pay_cnt + 11'd1;
              tot_cnt      <= tot_cnt + 11'd1;
            end
            if (s_last) begin
              err_oversize <= (pay_cnt == PAY_MAX);
              state <= (pay_cnt < PAD_LAST) ?
                       ST_PAD : ST_FCS;
            end
          end
        end
        ST_PAD: begin
          if (!fifo_full) begin
            fifo_wr      <= 1'b1;
            fifo_wr_data <= 8'h00;
            crc          <= crc_nxt;
            pay_cnt      <= pay_cnt + 11'd1;
            tot_cnt      <= tot_cnt + 11'd1;
            if (pay_cnt == PAD_LAST)
              state <= ST_FCS;
          end
        end
        ST_FCS: begin
          if (!fifo_full) begin
            fifo_wr      <= 1'b1;
            fifo_wr_data <= fcs_byte;
            fcs_idx      <= fcs_idx + 2'd1;
            tot_cnt      <= tot_cnt + 11'd1;
            if (fcs_idx == FCS_LAST) begin
              word_count       <= tot_cnt;
              word_count_ready <= 1'b1;
              state            <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (ack_s2) begin
            word_count_ready <= 1'b0;
            state            <= ST_WAIT_ACK_LOW;
          end
        end
        ST_WAIT_ACK_LOW: begin
          if (!ack_s2)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomised bench for eth_tx_framer against a queue-based
// frame model, with a GMII-side 4-phase responder.
module tb_eth_tx_framer;
  import eth_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr;
  logic        fifo_full;
  logic [10:0] word_count;
  logic        word_count_ready;
  logic        word_count_ack;
  logic        err_oversize;

  eth_tx_framer dut (
    .clk              (clk),
    .rst              (rst),
    .dst_mac          (dst_mac),
    .src_mac          (src_mac),
    .ethertype        (ethertype),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr          (fifo_wr),
    .fifo_full        (fifo_full),
    .word_count       (word_count),
    .word_count_ready (word_count_ready),
    .word_count_ack   (word_count_ack),
    .err_oversize     (err_oversize)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int full_mode = 0;
  logic full_prev = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] cur[$];
  int wc_q[$];
  int dly_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Non-reflected MSB-first register fed LSB-first bits;
  // its final value is the bit-reverse of the wire CRC.
  function automatic logic [31:0] raw_crc(
    input logic [7:0] q[$]
  );
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[k])
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ q[k][i];
        c = c << 1;
        if (fb) c = c ^ CRC32_POLY;
      end
    return c;
  endfunction

  function automatic void build(
    input logic [7:0] pay[$],
    output logic [7:0] frm[$]
  );
    logic [31:0] fcs;
    int np;
    frm.delete();
    for (int k = 5; k >= 0; k--)
      frm.push_back(dst_mac[k*8 +: 8]);
    for (int k = 5; k >= 0; k--)
      frm.push_back(src_mac[k*8 +: 8]);
    frm.push_back(ethertype[15:8]);
    frm.push_back(ethertype[7:0]);
    np = (pay.size() > 1500) ? 1500 : pay.size();
    for (int k = 0; k < np; k++)
      frm.push_back(pay[k]);
    for (int k = np; k < 46; k++)
      frm.push_back(8'h00);
    fcs = ~rev32(raw_crc(frm));
    for (int k = 0; k < 4; k++)
      frm.push_back(fcs[k*8 +: 8]);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (full_mode)
      1: fifo_full = ~fifo_full;
      2: fifo_full = ($urandom_range(0, 3) == 0);
      default: fifo_full = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (fifo_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got 0x%0h",
                 fifo_wr_data);
      end else
        chk("fifo_byte", fifo_wr_data,
            exp_q.pop_front());
      cur.push_back(fifo_wr_data);
    end
    if (full_prev)
      chk("no_write_when_full", fifo_wr, 0);
    full_prev = fifo_full;
    if (err_oversize) err_cnt++;
  end

  initial begin : resp
    int d, cnt, bad, ewc;
    logic [10:0] wc;
    word_count_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!word_count_ready) continue;
      wc = word_count;
      if (wc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got %0d", wc);
        ewc = 0;
        d = 1;
      end else begin
        ewc = wc_q.pop_front();
        d = dly_q.pop_front();
      end
      chk("word_count", 32'(wc), ewc);
      chk("err_pulses", err_cnt, exp_err);
      @(negedge clk);
      chk("frame_len", cur.size(), ewc + 1);
      chk("residue", raw_crc(cur), CRC32_RESIDUE);
      cur.delete();
      bad = 0;
      for (int k = 1; k < d; k++) begin
        @(negedge clk);
        if (word_count !== wc || !word_count_ready)
          bad++;
      end
      @(posedge clk);
      #3 word_count_ack = 1'b1;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (word_count !== wc) bad++;
      end while (word_count_ready && cnt < 8);
      chk("wc_stable", bad, 0);
      chk("ready_drop_late", 32'(cnt <= 4), 1);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      @(posedge clk);
      #3 word_count_ack = 1'b0;
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (fifo_wr) bad++;
      end
      chk("no_start_before_ack_low", bad, 0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_fifo_wr", fifo_wr, 0);
    chk("mid_rst_data", fifo_wr_data, 0);
    chk("mid_rst_wc", word_count, 0);
    chk("mid_rst_wcr", word_count_ready, 0);
    chk("mid_rst_err", err_oversize, 0);
    exp_q.delete();
    cur.delete();
    void'(wc_q.pop_back());
    void'(dly_q.pop_back());
  endtask

  task automatic send_frame(input int n,
                            input int dly,
                            input int abort_at,
                            input bit gaps,
                            input bit chk_rdy,
                            output int flen);
    logic [7:0] pay[$];
    logic [7:0] frm[$];
    int i, guard, stall;
    bit acc;
    dst_mac = {16'($urandom), 32'($urandom)};
    src_mac = {16'($urandom), 32'($urandom)};
    ethertype = 16'($urandom);
    for (int k = 0; k < n; k++)
      pay.push_back((n == 1) ? 8'hAB : 8'($urandom));
    build(pay, frm);
    flen = frm.size();
    foreach (frm[k]) exp_q.push_back(frm[k]);
    wc_q.push_back(flen - 1);
    dly_q.push_back(dly);
    i = 0;
    guard = 0;
    stall = 0;
    s_valid = 1'b1;
    s_data = pay[0];
    s_last = (n == 1);
    while (i < n) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (i > 0 && s_valid && !acc) stall++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got %0d of %0d",
                 i, n);
        break;
      end
      if (acc) begin
        i++;
        if (i == abort_at) begin
          do_reset();
          flen = 0;
          return;
        end
      end
      if (i < n) begin
        if (gaps && $urandom_range(0, 3) == 0)
          s_valid = 1'b0;
        else begin
          s_valid = 1'b1;
          s_data = pay[i];
          s_last = (i == n - 1);
        end
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (n > 1500) exp_err++;
    if (chk_rdy) chk("ready_through_last", stall, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected done");
    errors++;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $fatal(1);
  end

  initial begin : main
    logic [7:0] vec[$];
    int len, guard;
    rst = 1'b1;
    dst_mac = '0;
    src_mac = '0;
    ethertype = '0;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_data", fifo_wr_data, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_wcr", word_count_ready, 0);
    chk("rst_err", err_oversize, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 9; k++)
      vec.push_back(8'h31 + 8'(k));
    chk("model_crc_pin", ~rev32(raw_crc(vec)),
        32'hCBF43926);

    full_mode = 0;
    send_frame(1, 5, -1, 0, 0, len);
    chk("len_1byte", len, 64);
    send_frame(100, 2, -1, 1, 0, len);
    chk("len_100", len, 118);
    send_frame(1600, 3, -1, 0, 1, len);
    chk("len_1600", len, 1518);
    full_mode = 1;
    send_frame(46, 2, -1, 0, 0, len);
    chk("len_46", len, 64);
    full_mode = 0;
    send_frame(64, 20, -1, 0, 0, len);
    full_mode = 2;
    send_frame(80, 2, 30, 1, 0, len);
    send_frame(50, 2, -1, 1, 0, len);
    for (int f = 0; f < 8; f++) begin
      full_mode = $urandom_range(0, 2);
      send_frame($urandom_range(1, 120),
                 $urandom_range(1, 6), -1, 1, 0, len);
    end

    guard = 0;
    while ((wc_q.size() != 0 || exp_q.size() != 0 ||
            word_count_ready || word_count_ack) &&
           guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
    chk("drain_bytes", exp_q.size(), 0);
    chk("drain_frames", wc_q.size(), 0);
    chk("err_total", err_cnt, exp_err);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
